// File: rtl/tran_sched.sv
// tran_sched: two-requester frame scheduler in front of a byte/nibble packer.
// Grants one requester per frame (round-robin) and streams its items to the
// packer with one cycle of latency. An odd nibble count is padded to a whole
// byte, and a status pulse is issued at the end of each frame.
module tran_sched #(
    parameter int MAX_ITEMS = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       byte0,
    input  logic       byte1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       last0,
    input  logic       last1,
    output logic       ready0,
    output logic       ready1,
    output logic       tx_start,
    output logic       tx_byte,
    output logic [7:0] tx_data,
    output logic [1:0] grant,
    output logic       frame_done,
    output logic       frame_id,
    output logic       frame_err,
    output logic [7:0] frame_bytes
);

    // Item count at which a frame is forcibly closed (zero-based index).
    localparam logic [7:0] LAST_IDX = 8'(MAX_ITEMS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        PAD    = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t     state_q;
    logic       owner_q;        // requester index that owns the current frame
    logic       prefer1_q;      // round-robin pointer: 1 = requester 1 wins a tie
    logic       parity_q;       // odd number of nibble items so far
    logic       err_pend_q;     // error to report after the pad cycle
    logic [7:0] cnt_q;          // accepted items in this frame
    logic [8:0] units_q;        // half-byte units in this frame, saturating
    logic       tx_start_q;
    logic       tx_byte_q;
    logic [7:0] tx_data_q;
    logic [1:0] grant_q;
    logic       frame_done_q;
    logic       frame_id_q;
    logic       frame_err_q;
    logic [7:0] frame_bytes_q;

    logic       sel_valid_d;
    logic       sel_byte_d;
    logic       sel_last_d;
    logic [7:0] sel_data_d;
    logic       pick1_d;
    logic       parity_d;
    logic       end_frame_d;
    logic [8:0] units_item_d;
    logic [8:0] units_pad_d;

    function automatic logic [8:0] sat_add(input logic [8:0] u, input logic [1:0] inc);
        logic [9:0] sum;
        sum = {1'b0, u} + {8'd0, inc};
        return sum[9] ? 9'd511 : sum[8:0];
    endfunction

    // Select the owner's inputs and precompute the effect of accepting an item.
    always_comb begin
        sel_valid_d  = owner_q ? valid1 : valid0;
        sel_byte_d   = owner_q ? byte1  : byte0;
        sel_last_d   = owner_q ? last1  : last0;
        sel_data_d   = owner_q ? data1  : data0;
        pick1_d      = valid1 & (~valid0 | prefer1_q);
        parity_d     = parity_q ^ ~sel_byte_d;
        units_item_d = sat_add(units_q, sel_byte_d ? 2'd2 : 2'd1);
        units_pad_d  = sat_add(units_q, 2'd1);
        end_frame_d  = sel_last_d | (cnt_q == LAST_IDX);
    end

    // Frame FSM with all packer drive and status outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            prefer1_q     <= 1'b0;
            parity_q      <= 1'b0;
            err_pend_q    <= 1'b0;
            cnt_q         <= 8'd0;
            units_q       <= 9'd0;
            tx_start_q    <= 1'b0;
            tx_byte_q     <= 1'b0;
            tx_data_q     <= 8'h00;
            grant_q       <= 2'b00;
            frame_done_q  <= 1'b0;
            frame_id_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_bytes_q <= 8'h00;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid0 || valid1) begin
                        owner_q    <= pick1_d;
                        prefer1_q  <= ~pick1_d;
                        grant_q    <= pick1_d ? 2'b10 : 2'b01;
                        parity_q   <= 1'b0;
                        err_pend_q <= 1'b0;
                        cnt_q      <= 8'd0;
                        units_q    <= 9'd0;
                        state_q    <= STREAM;
                    end
                end
                STREAM: begin
                    if (sel_valid_d) begin
                        tx_start_q <= 1'b1;
                        tx_byte_q  <= sel_byte_d;
                        tx_data_q  <= sel_data_d;
                        parity_q   <= parity_d;
                        units_q    <= units_item_d;
                        cnt_q      <= cnt_q + 8'd1;
                        if (end_frame_d) begin
                            if (parity_d) begin
                                err_pend_q <= ~sel_last_d;
                                state_q    <= PAD;
                            end else begin
                                frame_done_q  <= 1'b1;
                                frame_id_q    <= owner_q;
                                frame_err_q   <= ~sel_last_d;
                                frame_bytes_q <= units_item_d[8:1];
                                state_q       <= GAP;
                            end
                        end
                    end else begin
                        // Bubble: close the frame at once, padding if a nibble is dangling.
                        frame_done_q <= 1'b1;
                        frame_id_q   <= owner_q;
                        frame_err_q  <= 1'b1;
                        tx_byte_q    <= 1'b0;
                        tx_data_q    <= 8'h00;
                        if (parity_q) begin
                            tx_start_q    <= 1'b1;
                            units_q       <= units_pad_d;
                            frame_bytes_q <= units_pad_d[8:1];
                        end else begin
                            tx_start_q    <= 1'b0;
                            frame_bytes_q <= units_q[8:1];
                        end
                        state_q <= GAP;
                    end
                end
                PAD: begin
                    tx_start_q    <= 1'b1;
                    tx_byte_q     <= 1'b0;
                    tx_data_q     <= 8'h00;
                    units_q       <= units_pad_d;
                    frame_done_q  <= 1'b1;
                    frame_id_q    <= owner_q;
                    frame_err_q   <= err_pend_q;
                    frame_bytes_q <= units_pad_d[8:1];
                    state_q       <= GAP;
                end
                GAP: begin
                    tx_start_q <= 1'b0;
                    tx_byte_q  <= 1'b0;
                    tx_data_q  <= 8'h00;
                    grant_q    <= 2'b00;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready0      = (state_q == STREAM) & grant_q[0];
    assign ready1      = (state_q == STREAM) & grant_q[1];
    assign tx_start    = tx_start_q;
    assign tx_byte     = tx_byte_q;
    assign tx_data     = tx_data_q;
    assign grant       = grant_q;
    assign frame_done  = frame_done_q;
    assign frame_id    = frame_id_q;
    assign frame_err   = frame_err_q;
    assign frame_bytes = frame_bytes_q;

endmodule

// File: tb/tb_tran_sched.sv
// Directed, table-driven bench for tran_sched (MAX_ITEMS = 4).
module tb_tran_sched;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid0, valid1, byte0, byte1, last0, last1;
    logic [7:0] data0, data1;
    logic       ready0, ready1, tx_start, tx_byte;
    logic [7:0] tx_data;
    logic [1:0] grant;
    logic       frame_done, frame_id, frame_err;
    logic [7:0] frame_bytes;

    int n_pass  = 0;
    int n_total = 0;

    tran_sched #(.MAX_ITEMS(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid0     (valid0),
        .valid1     (valid1),
        .byte0      (byte0),
        .byte1      (byte1),
        .data0      (data0),
        .data1      (data1),
        .last0      (last0),
        .last1      (last1),
        .ready0     (ready0),
        .ready1     (ready1),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .tx_data    (tx_data),
        .grant      (grant),
        .frame_done (frame_done),
        .frame_id   (frame_id),
        .frame_err  (frame_err),
        .frame_bytes(frame_bytes)
    );

    always #5 clk = ~clk;

    // ctl = {v0,v1,b0,b1,l0,l1}; ex = {r1,r0,txs,txb,grant[1:0],done,id,err}
    typedef struct packed {
        logic [5:0] ctl;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [8:0] ex;
        logic [7:0] ex_txd;
        logic [7:0] ex_bytes;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic [5:0] ctl, input logic [7:0] d0, input logic [7:0] d1);
        valid0 = ctl[5]; valid1 = ctl[4];
        byte0  = ctl[3]; byte1  = ctl[2];
        last0  = ctl[1]; last1  = ctl[0];
        data0  = d0;     data1  = d1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ready"},  {7'd0, ready1, ready0}, 9'd0);
        chk({tag, ".tx"},     {tx_start, tx_byte, tx_data}, 9'd0);
        chk({tag, ".grant"},  {7'd0, grant}, 9'd0);
        chk({tag, ".status"}, {frame_done, frame_id, frame_err, 6'd0}, 9'd0);
        chk({tag, ".bytes"},  {1'b0, frame_bytes}, 9'd0);
    endtask

    initial begin
        // Scenario A: req0 bytes A5, 3C(last)
        vecs[0]  = '{6'b10_10_00, 8'hA5, 8'h00, 9'b00_00_00_000, 8'h00, 8'h00};
        vecs[1]  = '{6'b10_10_00, 8'hA5, 8'h00, 9'b01_00_01_000, 8'h00, 8'h00};
        vecs[2]  = '{6'b10_10_10, 8'h3C, 8'h00, 9'b01_11_01_000, 8'hA5, 8'h00};
        vecs[3]  = '{6'b00_00_00, 8'h00, 8'h00, 9'b00_11_01_100, 8'h3C, 8'h02};
        // Scenario B: req1 nibbles 07, 02, 09(last) -> pad
        vecs[4]  = '{6'b01_00_00, 8'h00, 8'h07, 9'b00_00_00_000, 8'h00, 8'h00};
        vecs[5]  = '{6'b01_00_00, 8'h00, 8'h07, 9'b10_00_10_000, 8'h00, 8'h00};
        vecs[6]  = '{6'b01_00_00, 8'h00, 8'h02, 9'b10_10_10_000, 8'h07, 8'h00};
        vecs[7]  = '{6'b01_00_01, 8'h00, 8'h09, 9'b10_10_10_000, 8'h02, 8'h00};
        vecs[8]  = '{6'b00_00_00, 8'h00, 8'h00, 9'b00_10_10_000, 8'h09, 8'h00};
        vecs[9]  = '{6'b00_00_00, 8'h00, 8'h00, 9'b00_10_10_110, 8'h00, 8'h02};
        // Scenario C: both requesters continuously, one-byte frames
        vecs[10] = '{6'b11_11_11, 8'h11, 8'h22, 9'b00_00_00_000, 8'h00, 8'h00};
        vecs[11] = '{6'b11_11_11, 8'h11, 8'h22, 9'b01_00_01_000, 8'h00, 8'h00};
        vecs[12] = '{6'b11_11_11, 8'h11, 8'h22, 9'b00_11_01_100, 8'h11, 8'h01};
        vecs[13] = '{6'b11_11_11, 8'h11, 8'h22, 9'b00_00_00_000, 8'h00, 8'h00};
        vecs[14] = '{6'b11_11_11, 8'h11, 8'h22, 9'b10_00_10_000, 8'h00, 8'h00};
        vecs[15] = '{6'b11_11_11, 8'h11, 8'h22, 9'b00_11_10_110, 8'h22, 8'h01};
        vecs[16] = '{6'b11_11_11, 8'h11, 8'h22, 9'b00_00_00_000, 8'h00, 8'h00};
        vecs[17] = '{6'b11_11_11, 8'h11, 8'h22, 9'b01_00_01_000, 8'h00, 8'h00};
        vecs[18] = '{6'b00_00_00, 8'h00, 8'h00, 9'b00_11_01_100, 8'h11, 8'h01};
        // Scenario D: req0 nibble 04 then bubble -> immediate pad, error
        vecs[19] = '{6'b10_00_00, 8'h04, 8'h00, 9'b00_00_00_000, 8'h00, 8'h00};
        vecs[20] = '{6'b10_00_00, 8'h04, 8'h00, 9'b01_00_01_000, 8'h00, 8'h00};
        vecs[21] = '{6'b00_00_00, 8'h00, 8'h00, 9'b01_10_01_000, 8'h04, 8'h00};
        vecs[22] = '{6'b00_00_00, 8'h00, 8'h00, 9'b00_10_01_101, 8'h00, 8'h01};
        // Scenario E: req1 byte items without last, capped at 4
        vecs[23] = '{6'b01_01_00, 8'h00, 8'h01, 9'b00_00_00_000, 8'h00, 8'h00};
        vecs[24] = '{6'b01_01_00, 8'h00, 8'h01, 9'b10_00_10_000, 8'h00, 8'h00};
        vecs[25] = '{6'b01_01_00, 8'h00, 8'h02, 9'b10_11_10_000, 8'h01, 8'h00};
        vecs[26] = '{6'b01_01_00, 8'h00, 8'h03, 9'b10_11_10_000, 8'h02, 8'h00};
        vecs[27] = '{6'b01_01_00, 8'h00, 8'h04, 9'b10_11_10_000, 8'h03, 8'h00};
        vecs[28] = '{6'b01_01_00, 8'h00, 8'h05, 9'b00_11_10_111, 8'h04, 8'h04};
        vecs[29] = '{6'b00_00_00, 8'h00, 8'h00, 9'b00_00_00_000, 8'h00, 8'h00};

        // Reset state
        reset_n = 1'b0;
        drive(6'b0, 8'h00, 8'h00);
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_hold");
        reset_n = 1'b1;

        // Table-driven run
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].ctl, vecs[i].d0, vecs[i].d1);
            chk($sformatf("v%0d.ready", i), {7'd0, ready1, ready0}, {7'd0, vecs[i].ex[8:7]});
            chk($sformatf("v%0d.tx", i), {tx_start, tx_byte, tx_data},
                {vecs[i].ex[6:5], vecs[i].ex_txd});
            chk($sformatf("v%0d.grant", i), {7'd0, grant}, {7'd0, vecs[i].ex[4:3]});
            chk($sformatf("v%0d.done", i), {8'd0, frame_done}, {8'd0, vecs[i].ex[2]});
            if (vecs[i].ex[2]) begin
                chk($sformatf("v%0d.id_err", i), {7'd0, frame_id, frame_err},
                    {7'd0, vecs[i].ex[1:0]});
                chk($sformatf("v%0d.bytes", i), {1'b0, frame_bytes}, {1'b0, vecs[i].ex_bytes});
            end
            $display("vec %0d: ready=%b%b tx=%b/%b/%h grant=%b done=%b id=%b err=%b bytes=%0d",
                     i, ready1, ready0, tx_start, tx_byte, tx_data, grant,
                     frame_done, frame_id, frame_err, frame_bytes);
            @(posedge clk);
            #1;
        end

        // Reset pulsed mid-STREAM, then req1 alone
        drive(6'b10_10_00, 8'hAA, 8'h00);
        @(posedge clk); #1;
        chk("mid.grant", {7'd0, grant}, 9'b01);
        @(posedge clk); #1;
        chk("mid.tx_start", {8'd0, tx_start}, 9'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        $display("reset asserted mid-frame: tx_start=%b grant=%b", tx_start, grant);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("rst_no_done", {7'd0, frame_done, tx_start}, 9'd0);
        end
        drive(6'b01_01_01, 8'h00, 8'h5A);
        reset_n = 1'b1;
        chk("post.idle", {5'd0, ready1, ready0, grant}, 9'd0);
        @(posedge clk); #1;
        chk("post.grant", {5'd0, ready1, ready0, grant}, 9'b0_0010_10);
        @(posedge clk); #1;
        drive(6'b0, 8'h00, 8'h00);
        chk("post.done", {frame_done, frame_id, frame_err, 6'd0}, 9'b110_000000);
        chk("post.tx", {tx_start, tx_byte, tx_data}, {2'b11, 8'h5A});
        chk("post.bytes", {1'b0, frame_bytes}, 9'd1);
        $display("post-reset frame: done=%b id=%b err=%b bytes=%0d", frame_done, frame_id,
                 frame_err, frame_bytes);
        @(posedge clk); #1;
        chk("post.end", {6'd0, frame_done, grant}, 9'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
